// File: rtl/sd_rr_burst_arb.sv
// sd_rr_burst_arb: round-robin arbiter that locks a grant for up to max_burst beats and feeds one registered srdy/drdy output.
module sd_rr_burst_arb #(
  parameter int width = 8,
  parameter int inputs = 4,
  parameter int max_burst = 4,
  parameter int isz = $clog2(inputs),
  parameter int bsz = $clog2(max_burst + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [inputs-1:0]       c_srdy,
  input  logic [inputs*width-1:0] c_data,
  output logic [inputs-1:0]       c_drdy,
  output logic                    p_srdy,
  output logic [width-1:0]        p_data,
  output logic [isz-1:0]          p_grant,
  input  logic                    p_drdy,
  output logic                    busy
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nxt;
  logic [isz-1:0] rr_ptr, rr_nxt, owner, owner_nxt, sel, g;
  logic [bsz-1:0] cnt, cnt_nxt;
  logic load, req, xfer;
  function automatic logic [isz-1:0] inc(input logic [isz-1:0] v);
    return (int'(v) == inputs - 1) ? '0 : v + 1'b1;
  endfunction
  assign load = ~p_srdy | p_drdy;
  assign req = |c_srdy;
  assign busy = (state == BURST);
  assign g = busy ? owner : sel;
  assign xfer = |(c_srdy & c_drdy);
  // Descending scan so the requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    sel = '0;
    for (int j = inputs - 1; j >= 0; j--)
      if (c_srdy[(int'(rr_ptr) + j) % inputs]) sel = isz'((int'(rr_ptr) + j) % inputs);
  end
  always_comb begin
    state_nxt = state;
    rr_nxt = rr_ptr;
    owner_nxt = owner;
    cnt_nxt = cnt;
    c_drdy = reset ? '0 : busy ? ((inputs'(1) << owner) & {inputs{load}})
                               : ((inputs'(1) << sel) & {inputs{load & req}});
    if (!busy) begin
      if (xfer && max_burst == 1) rr_nxt = inc(sel);
      else if (xfer) begin
        owner_nxt = sel;
        cnt_nxt = bsz'(1);
        state_nxt = BURST;
      end
    end else if (!c_srdy[owner] || (xfer && int'(cnt) + 1 == max_burst)) begin
      state_nxt = IDLE;
      rr_nxt = inc(owner);
    end else if (xfer) cnt_nxt = cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      cnt <= '0;
      p_srdy <= 1'b0;
      p_data <= '0;
      p_grant <= '0;
    end else begin
      state <= state_nxt;
      rr_ptr <= rr_nxt;
      owner <= owner_nxt;
      cnt <= cnt_nxt;
      if (xfer) begin
        p_srdy <= 1'b1;
        p_data <= c_data[int'(g)*width +: width];
        p_grant <= g;
      end else if (p_drdy) p_srdy <= 1'b0;
    end
  end
`ifdef SD_INLINE_ASSERTION_ON
  a_drdy_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(c_drdy));
  a_hold: assert property (@(posedge clk) disable iff (reset)
    p_srdy && !p_drdy |=> $stable(p_data) && $stable(p_grant));
  a_cnt: assert property (@(posedge clk) disable iff (reset) int'(cnt) <= max_burst);
`endif
endmodule
